// File: rtl/pipeline_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_pkg
//   Shared definitions for the instruction-fetch stage:
//   - NOP_WORD   : word delivered for faulted fetches (sll $0,$0,0)
//   - buf_state_e: occupancy of the output register + skid register pair
//   - fetch_entry_t: one fetched entry {instr, pc, fault}
//   The entry struct is sized by FE_DATA_W / FE_PC_W; instances of
//   instr_fetch_mem must use matching DATA_W / PC_W.
// ---------------------------------------------------------------------------
package pipeline_pkg;

    localparam int FE_DATA_W = 32;
    localparam int FE_PC_W   = 32;

    localparam logic [FE_DATA_W-1:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_e;

    typedef struct packed {
        logic [FE_DATA_W-1:0] instr;
        logic [FE_PC_W-1:0]   pc;
        logic                 fault;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_mem_sram.sv
// ---------------------------------------------------------------------------
// imem_sram_1r1w
//   One-read one-write instruction array with a registered read port.
//   Write and read on the same edge to the same word return the OLD word
//   (read-first); the array itself has no reset.
//   Optional feature macro: IMEM_PARITY_EN
//     defined   : each word carries an extra even-parity bit written with the
//                 data; rpar_bad flags a mismatch on the registered read word.
//     undefined : array is DATA_W wide, rpar_bad is constant 0.
// Ports
//   clk, rst_n          clock, async active-low reset (read register only)
//   re, raddr           read enable / word address (data valid after the edge)
//   rdata, rpar_bad     registered read word and its parity check result
//   we, waddr, wdata    program-load write port
// ---------------------------------------------------------------------------
module imem_sram_1r1w #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata,
    output logic              rpar_bad,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata
);

`ifdef IMEM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    logic [MEM_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic [MEM_W-1:0] wword;
    logic [MEM_W-1:0] q;

`ifdef IMEM_PARITY_EN
    // Parity bit makes the XOR over the whole stored word zero.
    assign wword    = {^wdata, wdata};
    assign rpar_bad = ^q;
`else
    assign wword    = wdata;
    assign rpar_bad = 1'b0;
`endif

    assign rdata = q[DATA_W-1:0];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wword;
        end
    end

    // Non-blocking read samples the array before the same-edge write lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (re) begin
            q <= mem[raddr];
        end
    end

endmodule

// File: rtl/instr_fetch_mem.sv
// ---------------------------------------------------------------------------
// instr_fetch_mem
//   Instruction memory at the IF/ID boundary. A byte PC request is accepted
//   when req_valid && req_ready; the fetched word appears on the output the
//   cycle after the accepting edge. A two-entry buffer (output slot + skid
//   slot) absorbs decode stalls so no accepted fetch is lost.
//   Optional feature macro: IMEM_PARITY_EN (parity column, sticky parity_err).
//
//   Handshakes: a transfer happens on a rising edge where valid && ready are
//   both high; a producer holds its payload stable while valid && !ready.
//   req_ready is a flop (state != BUF_TWO) and never depends on out_ready in
//   the same cycle.
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   req_valid, req_pc, req_ready   fetch request channel
//   flush                      drop everything held and any same-cycle accept
//   out_valid, out_ready       fetched-entry channel to decode
//   instr_out, out_pc, fault   entry payload; fault = misaligned/out of range
//                              (or parity mismatch when enabled)
//   prog_we, prog_addr, prog_data  program-load write port (word address)
//   parity_err                 sticky parity error flag (0 without the macro)
// ---------------------------------------------------------------------------
module instr_fetch_mem #(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 4,
    parameter int                PC_W     = 32,
    parameter logic [DATA_W-1:0] NOP_WORD = pipeline_pkg::NOP_WORD
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic [PC_W-1:0]   req_pc,
    output logic              req_ready,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] instr_out,
    output logic [PC_W-1:0]   out_pc,
    output logic              fault,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic              parity_err
);

    import pipeline_pkg::*;

    buf_state_e   state;
    buf_state_e   state_nxt;
    logic         req_ready_q;
    logic         accept;
    logic         addr_fault;

    logic [DATA_W-1:0] rd_data;
    logic              rd_par_bad;

    // Metadata of the most recently accepted request; its data word is the
    // SRAM read register, which only changes on accept.
    logic [PC_W-1:0] last_pc;
    logic            last_fault;
    logic            last_par;
    fetch_entry_t    last_ent;

    // Older entry parked here when a second word arrives during a stall.
    fetch_entry_t    held_ent;
    fetch_entry_t    cur_ent;

    assign req_ready  = req_ready_q;
    assign accept     = req_valid && req_ready_q;
    assign addr_fault = (req_pc[1:0] != 2'b00) || (req_pc[PC_W-1:ADDR_W+2] != '0);

    imem_sram_1r1w #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_sram (
        .clk      (clk),
        .rst_n    (rst_n),
        .re       (accept),
        .raddr    (req_pc[ADDR_W+1:2]),
        .rdata    (rd_data),
        .rpar_bad (rd_par_bad),
        .we       (prog_we),
        .waddr    (prog_addr),
        .wdata    (prog_data)
    );

    // A parity mismatch only matters for a word that was really fetched.
    assign last_par = rd_par_bad && !last_fault;

    always_comb begin
        last_ent       = '0;
        last_ent.pc    = last_pc;
        last_ent.fault = last_fault || last_par;
        last_ent.instr = (last_fault || last_par) ? NOP_WORD : rd_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_pc    <= '0;
            last_fault <= 1'b0;
        end else if (accept) begin
            last_pc    <= req_pc;
            last_fault <= addr_fault;
        end
    end

    // ONE -> TWO: the read register is about to be overwritten by the new
    // word, so the word currently shown moves to the held slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_ent <= '0;
        end else if (state == BUF_ONE && accept && !out_ready && !flush) begin
            held_ent <= last_ent;
        end
    end

    // Buffer FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= BUF_EMPTY;
            req_ready_q <= 1'b1;
        end else begin
            state       <= state_nxt;
            req_ready_q <= (state_nxt != BUF_TWO);
        end
    end

    // Buffer FSM: next state and outputs
    always_comb begin
        state_nxt = state;
        out_valid = 1'b0;
        cur_ent   = last_ent;
        case (state)
            BUF_EMPTY: begin
                if (accept) state_nxt = BUF_ONE;
            end
            BUF_ONE: begin
                out_valid = 1'b1;
                if (accept && !out_ready) state_nxt = BUF_TWO;
                else if (!accept && out_ready) state_nxt = BUF_EMPTY;
            end
            BUF_TWO: begin
                out_valid = 1'b1;
                cur_ent   = held_ent;
                if (out_ready) state_nxt = BUF_ONE;
            end
            default: state_nxt = BUF_EMPTY;
        endcase
        if (flush) state_nxt = BUF_EMPTY;
    end

    assign instr_out = cur_ent.instr;
    assign out_pc    = cur_ent.pc;
    assign fault     = cur_ent.fault;

`ifdef IMEM_PARITY_EN
    logic held_par;
    logic cur_par;
    logic parity_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_par <= 1'b0;
        end else if (state == BUF_ONE && accept && !out_ready && !flush) begin
            held_par <= last_par;
        end
    end

    assign cur_par = (state == BUF_TWO) ? held_par : last_par;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_err_q <= 1'b0;
        end else if (out_valid && cur_par) begin
            parity_err_q <= 1'b1;
        end
    end

    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_mem.sv
module tb_instr_fetch_mem;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic [31:0] req_pc = '0;
    logic        req_ready;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] instr_out;
    logic [31:0] out_pc;
    logic        fault;
    logic        prog_we = 1'b0;
    logic [3:0]  prog_addr = '0;
    logic [31:0] prog_data = '0;
    logic        parity_err;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    instr_fetch_mem #(
        .DATA_W (32),
        .ADDR_W (4),
        .PC_W   (32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_pc     (req_pc),
        .req_ready  (req_ready),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .instr_out  (instr_out),
        .out_pc     (out_pc),
        .fault      (fault),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data),
        .parity_err (parity_err)
    );

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        fault;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mem_m [0:15];
    int          n_checks = 0;
    int          n_fail = 0;
    bit          chk_en = 1'b1;
    exp_t        model_e;
    bit          model_rdy;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model_fetch(input logic [31:0] pc);
        exp_t e;
        e.pc    = pc;
        e.fault = (pc[1:0] != 2'b00) || (pc[31:6] != '0);
        e.instr = e.fault ? NOP : mem_m[pc[5:2]];
        return e;
    endfunction

    function automatic logic [31:0] word_of(input int i);
        return 32'hC0DE_0000 | i;
    endfunction

    // Model: ordered queue of accepted fetches, capacity two.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            model_rdy = (exp_q.size() < 2);
            model_e   = model_fetch(req_pc);
            if (flush) begin
                exp_q.delete();
            end else begin
                if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
                if (req_valid && model_rdy) exp_q.push_back(model_e);
            end
            if (prog_we) mem_m[prog_addr] = prog_data;
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
            check("req_ready", 64'(req_ready), 64'(exp_q.size() < 2));
            check("parity_err", 64'(parity_err), 64'(0));
            if (exp_q.size() != 0) begin
                check("instr_out", 64'(instr_out), 64'(exp_q[0].instr));
                check("out_pc", 64'(out_pc), 64'(exp_q[0].pc));
                check("fault", 64'(fault), 64'(exp_q[0].fault));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] pc);
        req_valid = 1'b1;
        req_pc    = pc;
        tick();
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        // reset
        tick();
        tick();
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_instr_out", 64'(instr_out), 64'(0));
        check("rst_out_pc", 64'(out_pc), 64'(0));
        check("rst_fault", 64'(fault), 64'(0));
        check("rst_parity_err", 64'(parity_err), 64'(0));
        check("rst_req_ready", 64'(req_ready), 64'(1));
        rst_n = 1'b1;
        tick();

        // program load
        for (int i = 0; i < 16; i++) begin
            prog_we   = 1'b1;
            prog_addr = 4'(i);
            prog_data = word_of(i);
            tick();
        end
        prog_we = 1'b0;

        // 1: back-to-back fetch, no stall
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            fetch(32'(k * 4));
            check("t1_instr", 64'(instr_out), 64'(32'hC0DE_0000 + k));
            check("t1_pc", 64'(out_pc), 64'(k * 4));
            check("t1_ready", 64'(req_ready), 64'(1));
        end
        idle(1);
        check("t1_drained", 64'(out_valid), 64'(0));

        // 2: stall three cycles, buffer fills to two
        out_ready = 1'b0;
        fetch(32'h10);
        check("t2_first", 64'(instr_out), 64'(32'hC0DE_0004));
        fetch(32'h14);
        check("t2_full_ready", 64'(req_ready), 64'(0));
        check("t2_hold_instr", 64'(instr_out), 64'(32'hC0DE_0004));
        fetch(32'h18);
        check("t2_hold_pc", 64'(out_pc), 64'(32'h10));
        out_ready = 1'b1;
        tick();
        check("t2_skid_out", 64'(instr_out), 64'(32'hC0DE_0005));
        tick();
        check("t2_next", 64'(instr_out), 64'(32'hC0DE_0006));
        fetch(32'h1C);
        check("t2_last", 64'(instr_out), 64'(32'hC0DE_0007));
        idle(1);

        // 3: faulting PCs
        fetch(32'h6);
        check("t3_mis_fault", 64'(fault), 64'(1));
        check("t3_mis_instr", 64'(instr_out), 64'(NOP));
        check("t3_mis_pc", 64'(out_pc), 64'(32'h6));
        fetch(32'h40);
        check("t3_oor_fault", 64'(fault), 64'(1));
        check("t3_oor_pc", 64'(out_pc), 64'(32'h40));
        idle(1);

        // 4: flush while full, and flush with an accepted request
        out_ready = 1'b0;
        fetch(32'h20);
        fetch(32'h24);
        flush = 1'b1;
        fetch(32'h28);
        check("t4_flush_valid", 64'(out_valid), 64'(0));
        check("t4_flush_ready", 64'(req_ready), 64'(1));
        flush = 1'b0;
        out_ready = 1'b1;
        fetch(32'h2C);
        check("t4_after_flush", 64'(instr_out), 64'(32'hC0DE_000B));
        flush = 1'b1;
        fetch(32'h30);
        flush = 1'b0;
        check("t4_drop_accept", 64'(out_valid), 64'(0));
        idle(1);
        check("t4_still_empty", 64'(out_valid), 64'(0));

        // 5: write and fetch the same word on one edge
        prog_we   = 1'b1;
        prog_addr = 4'd3;
        prog_data = 32'hDEAD_BEEF;
        fetch(32'hC);
        prog_we = 1'b0;
        check("t5_old_word", 64'(instr_out), 64'(32'hC0DE_0003));
        fetch(32'hC);
        check("t5_new_word", 64'(instr_out), 64'(32'hDEAD_BEEF));
        idle(1);

        // mixed request / stall pattern, checked by the model
        for (int i = 0; i < 24; i++) begin
            req_valid = (i % 3 != 2);
            out_ready = (i % 4 != 1) && (i % 5 != 3);
            req_pc    = (i == 7) ? 32'h41 : 32'((i * 4) % 64);
            tick();
        end
        out_ready = 1'b1;
        idle(3);

        // 6: parity
`ifdef IMEM_PARITY_EN
        chk_en = 1'b0;
        dut.u_sram.mem[5][0] = ~dut.u_sram.mem[5][0];
        fetch(32'h14);
        check("t6_fault", 64'(fault), 64'(1));
        check("t6_instr", 64'(instr_out), 64'(NOP));
        idle(1);
        check("t6_perr_set", 64'(parity_err), 64'(1));
        idle(3);
        check("t6_perr_sticky", 64'(parity_err), 64'(1));
        dut.u_sram.mem[5][0] = ~dut.u_sram.mem[5][0];
`else
        fetch(32'h14);
        check("t6_no_fault", 64'(fault), 64'(0));
        idle(1);
        check("t6_perr_zero", 64'(parity_err), 64'(0));
`endif

        // asynchronous reset while holding a word
        out_ready = 1'b0;
        fetch(32'h8);
        req_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 64'(out_valid), 64'(0));
        check("arst_ready", 64'(req_ready), 64'(1));
        check("arst_instr", 64'(instr_out), 64'(0));
        check("arst_perr", 64'(parity_err), 64'(0));
        tick();
        rst_n = 1'b1;
        chk_en = 1'b1;
        out_ready = 1'b1;
        tick();
        fetch(32'h4);
        check("arst_mem_kept", 64'(instr_out), 64'(32'hC0DE_0001));
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
